// File: rtl/temporizador_multicanal_pkg.sv
// temporizador_pkg: shared state encoding and channel-index width helper
//   estado_t : sequencer states IDLE, RUN, NEXT, DONE
//   ch_w(n)  : channel index width, max(1, clog2(n))
package temporizador_pkg;

    typedef enum logic [1:0] {IDLE, RUN, NEXT, DONE} estado_t;

    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/temporizador_multicanal_if.sv
// temporizador_multicanal_if: control/status bundle between parameter logic and the sequencer
//   i_enter     start request          i_abort     synchronous cancel
//   i_repetir   repeat mode            i_dur       packed per-channel durations
//   o_motor_en  one-hot-or-zero enables  o_flag    per-channel completion pulse
//   o_canal_act active channel index   o_busy      not idle   o_done  end-of-sequence pulse
interface temporizador_multicanal_if
    import temporizador_pkg::*;
#(
    parameter int N_CH  = 3,
    parameter int CNT_W = 8
);
    localparam int CH_W = ch_w(N_CH);

    logic                    i_enter;
    logic                    i_abort;
    logic                    i_repetir;
    logic [N_CH*CNT_W-1:0]   i_dur;
    logic [N_CH-1:0]         o_motor_en;
    logic [N_CH-1:0]         o_flag;
    logic [CH_W-1:0]         o_canal_act;
    logic                    o_busy;
    logic                    o_done;

    modport master (
        output i_enter, i_abort, i_repetir, i_dur,
        input  o_motor_en, o_flag, o_canal_act, o_busy, o_done
    );

    modport slave (
        input  i_enter, i_abort, i_repetir, i_dur,
        output o_motor_en, o_flag, o_canal_act, o_busy, o_done
    );

endinterface

// File: rtl/temporizador_multicanal_divisor_tick.sv
// divisor_tick: clock prescaler emitting one tick every PRESC_DIV enabled cycles
//   clk, rst  clock and asynchronous active-high reset
//   i_clr     restart count from zero (wins over i_en)
//   i_en      count enable
//   o_tick    high on the enabled cycle where the count reaches PRESC_DIV-1
module divisor_tick #(
    parameter int PRESC_DIV = 50000,
    parameter int PRESC_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    logic [PRESC_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == PRESC_W'(PRESC_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else
            r_cnt <= i_clr ? '0 : !i_en ? r_cnt : o_tick ? '0 : r_cnt + PRESC_W'(1);
    end

endmodule

// File: rtl/temporizador_multicanal.sv
// temporizador_multicanal: runs N_CH motor channels in turn for latched tick durations
//   clk, rst  clock and asynchronous active-high reset
//   bus       temporizador_multicanal_if.slave: enter/abort/repetir/dur in,
//             motor_en/flag/canal_act/busy/done out, all decoded from registered state
module temporizador_multicanal
    import temporizador_pkg::*;
#(
    parameter int N_CH      = 3,
    parameter int CNT_W     = 8,
    parameter int PRESC_DIV = 50000,
    parameter int PRESC_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    temporizador_multicanal_if.slave    bus
);

    localparam int CH_W = ch_w(N_CH);

    estado_t               r_state, w_next;
    logic [CH_W-1:0]       r_ch;
    logic [CNT_W-1:0]      r_cnt;
    logic [N_CH*CNT_W-1:0] r_dur;
    logic [CNT_W-1:0]      w_d;
    logic                  w_tick;
    logic                  w_zero;
    logic                  w_last;
    logic                  w_final;

    assign w_d     = r_dur[r_ch*CNT_W +: CNT_W];
    assign w_zero  = (w_d == '0);
    assign w_last  = (r_cnt == w_d - CNT_W'(1));
    assign w_final = (r_ch == CH_W'(N_CH - 1));

    // Held clear outside RUN so every RUN entry starts a fresh tick period.
    divisor_tick #(
        .PRESC_DIV (PRESC_DIV),
        .PRESC_W   (PRESC_W)
    ) u_div (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (r_state != RUN),
        .i_en   (r_state == RUN),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        bus.o_busy      = (r_state != IDLE);
        bus.o_done      = (r_state == DONE);
        bus.o_canal_act = (r_state == RUN || r_state == NEXT) ? r_ch : '0;
        bus.o_motor_en  = '0;
        bus.o_flag      = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.o_motor_en[i] = (r_state == RUN) && (r_ch == CH_W'(i)) && !w_zero;
            bus.o_flag[i]     = (r_state == NEXT) && (r_ch == CH_W'(i));
        end
        case (r_state)
            IDLE:    w_next = (bus.i_enter && !bus.i_abort) ? RUN : IDLE;
            RUN:     w_next = bus.i_abort ? IDLE : (w_zero || (w_tick && w_last)) ? NEXT : RUN;
            NEXT:    w_next = bus.i_abort ? IDLE : w_final ? DONE : RUN;
            DONE:    w_next = (bus.i_abort || !bus.i_repetir) ? IDLE : RUN;
            default: w_next = IDLE;
        endcase
    end

    // Durations latch only on the IDLE->RUN start; a repeat pass reuses them.
    // The tick counter resets on its final tick so it never reaches D.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dur <= '0;
            r_ch  <= '0;
            r_cnt <= '0;
        end else begin
            r_dur <= (r_state == IDLE && w_next == RUN) ? bus.i_dur : r_dur;
            r_ch  <= (r_state == NEXT && w_next == RUN) ? r_ch + CH_W'(1) :
                     (r_state == RUN || r_state == NEXT) ? r_ch : '0;
            r_cnt <= (r_state != RUN || (w_tick && w_last)) ? '0 : r_cnt + CNT_W'(w_tick);
        end
    end

endmodule

// File: tb/tb_temporizador_multicanal.sv
// tb_temporizador_multicanal: directed scoreboard bench, per-cycle expected output traces
module tb_temporizador_multicanal;

    typedef logic [9:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   sel = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    vec_t q[$];

    always #5 clk = ~clk;

    temporizador_multicanal_if #(.N_CH(3), .CNT_W(5)) b0 ();
    temporizador_multicanal_if #(.N_CH(3), .CNT_W(5)) b1 ();

    temporizador_multicanal #(.N_CH(3), .CNT_W(5), .PRESC_DIV(4), .PRESC_W(4)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    temporizador_multicanal #(.N_CH(3), .CNT_W(5), .PRESC_DIV(1), .PRESC_W(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    function automatic vec_t obs();
        return sel ? {b1.o_motor_en, b1.o_flag, b1.o_canal_act, b1.o_busy, b1.o_done}
                   : {b0.o_motor_en, b0.o_flag, b0.o_canal_act, b0.o_busy, b0.o_done};
    endfunction

    task automatic cmp_pop(input string tag);
        vec_t e, o;
        if (q.size() > 0) begin
            e = q.pop_front();
            o = obs();
            n_tests++;
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, o, e);
            end
        end
    endtask

    task automatic tick_chk(input string tag);
        @(posedge clk);
        #1;
        cmp_pop(tag);
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) tick_chk(tag);
    endtask

    // Expected trace of one full pass over channels 0..2, starting the cycle after the start edge.
    task automatic push_pass(input logic [14:0] d, input int p, input bit last);
        int dc;
        for (int c = 0; c < 3; c++) begin
            dc = int'(d[c*5 +: 5]);
            if (dc == 0) q.push_back({3'b000, 3'b000, 2'(c), 2'b10});
            else repeat (dc * p) q.push_back({3'(1 << c), 3'b000, 2'(c), 2'b10});
            q.push_back({3'b000, 3'(1 << c), 2'(c), 2'b10});
        end
        q.push_back({8'b0, 2'b11});
        if (last) q.push_back(10'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        b0.i_enter = 0; b0.i_abort = 0; b0.i_repetir = 0; b0.i_dur = '0;
        b1.i_enter = 0; b1.i_abort = 0; b1.i_repetir = 0; b1.i_dur = '0;
        #2;
        q.push_back(10'b0);
        cmp_pop("reset");
        @(posedge clk); #1;
        rst = 0;
        repeat (2) tick_chk("idle");

        b0.i_dur = {5'd1, 5'd3, 5'd2};
        b0.i_enter = 1;
        push_pass(b0.i_dur, 4, 1);
        tick_chk("basic");
        b0.i_enter = 0;
        drain("basic");

        b0.i_dur = {5'd2, 5'd0, 5'd2};
        b0.i_enter = 1;
        push_pass(b0.i_dur, 4, 1);
        tick_chk("zero_dur");
        b0.i_enter = 0;
        drain("zero_dur");

        b0.i_dur = {5'd1, 5'd3, 5'd2};
        b0.i_enter = 1;
        repeat (8) q.push_back({3'b001, 3'b000, 2'd0, 2'b10});
        q.push_back({3'b000, 3'b001, 2'd0, 2'b10});
        repeat (5) q.push_back({3'b010, 3'b000, 2'd1, 2'b10});
        repeat (3) q.push_back(10'b0);
        tick_chk("abort");
        b0.i_enter = 0;
        repeat (13) tick_chk("abort");
        b0.i_abort = 1;
        tick_chk("abort");
        b0.i_abort = 0;
        drain("abort_idle");
        b0.i_enter = 1;
        push_pass(b0.i_dur, 4, 1);
        tick_chk("restart");
        b0.i_enter = 0;
        drain("restart");

        b0.i_dur = {5'd1, 5'd1, 5'd1};
        b0.i_repetir = 1;
        b0.i_enter = 1;
        push_pass(b0.i_dur, 4, 0);
        push_pass(b0.i_dur, 4, 1);
        tick_chk("repeat");
        b0.i_enter = 0;
        repeat (4) tick_chk("repeat");
        b0.i_dur = {5'd7, 5'd7, 5'd7};
        repeat (15) tick_chk("repeat");
        b0.i_repetir = 0;
        drain("repeat");

        b0.i_dur = {5'd1, 5'd3, 5'd2};
        b0.i_enter = 1;
        push_pass(b0.i_dur, 4, 1);
        tick_chk("busy_enter");
        b0.i_enter = 0;
        repeat (3) tick_chk("busy_enter");
        b0.i_enter = 1;
        b0.i_dur = {5'd9, 5'd9, 5'd9};
        tick_chk("busy_enter");
        b0.i_enter = 0;
        repeat (10) tick_chk("busy_enter");
        b0.i_enter = 1;
        tick_chk("busy_enter");
        b0.i_enter = 0;
        drain("busy_enter");

        b0.i_dur = {5'd1, 5'd3, 5'd2};
        b0.i_enter = 1;
        repeat (5) q.push_back({3'b001, 3'b000, 2'd0, 2'b10});
        tick_chk("async_rst_pre");
        b0.i_enter = 0;
        repeat (4) tick_chk("async_rst_pre");
        #1;
        rst = 1;
        #1;
        q.push_back(10'b0);
        cmp_pop("async_rst");
        #1;
        rst = 0;
        q.push_back(10'b0);
        tick_chk("after_rst");

        sel = 1;
        b1.i_dur = {5'd0, 5'd0, 5'd31};
        b1.i_enter = 1;
        push_pass(b1.i_dur, 1, 1);
        tick_chk("max_dur");
        b1.i_enter = 0;
        drain("max_dur");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/temporizador_multicanal.md
Name: temporizador_multicanal

Overview:
Parametrised successor of the RGB motor-timing sequencer. On a start pulse it latches N_CH per-channel durations, then runs channels 0..N_CH-1 one after another. Each channel drives its motor enable for a programmable number of prescaled ticks and pulses a per-channel completion flag. Adds abort, repeat mode, a busy/done handshake and a built-in tick prescaler; it sits between the user-input/parameter logic and the motor drivers.

Parameters:
N_CH, 3, number of sequenced channels (>=1)
CNT_W, 8, width of each channel duration in ticks
PRESC_DIV, 50000, clk cycles per tick (>=1)
PRESC_W, 16, prescaler counter width, must hold PRESC_DIV-1
CH_W (localparam), max(1,clog2(N_CH)), channel index width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
enter  in  1  start request, sampled only in IDLE
abort  in  1  synchronous cancel, valid in any state
repetir  in  1  repeat mode, sampled in DONE
dur  in  N_CH*CNT_W  channel i duration at bits [i*CNT_W +: CNT_W], in ticks
motor_en  out  N_CH  one-hot-or-zero motor enables
flag  out  N_CH  one-cycle completion pulse per channel
canal_act  out  CH_W  index of channel in RUN/NEXT, else 0
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (async, any time): state IDLE, counters 0, latched durations 0. motor_en, flag, done, busy and canal_act are all 0 immediately, without waiting for clk.
- States: IDLE, RUN, NEXT, DONE. Outputs decode from registered state; motor_en[i] = (state==RUN && canal_act==i && dur_lat[i]!=0).
- IDLE: if enter && !abort, latch all of dur into dur_lat, set canal_act=0, clear tick/prescaler counters, go to RUN. dur changes outside IDLE have no effect.
- Prescaler: counts 0..PRESC_DIV-1 in RUN only and emits tick when it equals PRESC_DIV-1. It clears on every RUN entry. PRESC_DIV=1 gives a tick every cycle.
- RUN with dur_lat[ch]=D>0: tick counter increments per tick. On the tick where cnt==D-1, go to NEXT. Motor is high exactly D*PRESC_DIV cycles.
- RUN with D==0: exactly one cycle in RUN with motor low, then NEXT.
- NEXT (one cycle): flag[canal_act]=1, all motors low. If canal_act==N_CH-1, go to DONE; else canal_act+1 and RUN.
- DONE (one cycle): done=1. If repetir, go to RUN with canal_act=0 and the same dur_lat; no new latch. Else go to IDLE.
- enter in any state other than IDLE is ignored.
- abort: from any non-IDLE state, next edge goes to IDLE with motors low. No flag or done is emitted for the aborted channel. abort has priority over enter in IDLE and over the NEXT/DONE transitions.
- Maximum duration (2^CNT_W-1) works without wrap. The tick counter is CNT_W bits and never exceeds D-1.
- Latency: enter sampled at edge k makes motor_en[0] high from cycle k+1 (if D0>0). Gap between consecutive channel motors is exactly 1 cycle (NEXT).

Decomposition:
- Package temporizador_pkg: state enum (IDLE, RUN, NEXT, DONE) and a helper for CH_W/clog2.
- One sub-module, divisor_tick: the PRESC_DIV prescaler with clr and en inputs and a tick output, parametrised by PRESC_DIV and PRESC_W.

Test Plan:
(Bench parameters for all scenarios: N_CH=3, CNT_W=5, PRESC_DIV=4.)
- Basic sequence, dur={B=1,G=3,R=2}, enter 1 cycle -> motor_en=001 for 8 cycles, 1 gap cycle with flag=001; 010 for 12 cycles, gap with flag=010; 100 for 4 cycles, gap with flag=100. Then done=1 for one cycle, then busy=0.
- Zero duration, dur G=0, R=B=2 -> channel 1 takes one RUN cycle with motor_en=000, then flag=010 in the next cycle. Total sequence = 8+1+1+1+8+1+1 cycles.
- abort at cycle 5 of channel 1 -> motor_en=000 and busy=0 next cycle. No flag[1] and no done. A subsequent enter restarts at channel 0.
- Repeat mode, repetir=1, dur all 1 -> after done, motor_en=001 the next cycle; two full passes observed. Changing dur mid-run does not change the second pass.
- enter pulsed while busy, and dur changed mid-run -> no restart, timing unchanged. rst asserted mid-channel asynchronously -> all outputs 0 before the next clk edge.
- Boundary, dur R=31, PRESC_DIV=1 -> motor_en[0] high exactly 31 cycles, with no counter wrap.
